// File: rtl/game_pkg.sv
// Shared game definitions: state encoding, default sprite sizes, timing constants
// and the axis-overlap helper used by collision detection.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b01,
    ST_DEAD = 2'b10,
    ST_WIN  = 2'b11
  } game_state_t;

  localparam int DEF_PLAYER_W = 16;
  localparam int DEF_PLAYER_H = 16;
  localparam int DEF_ENEMY_W  = 16;
  localparam int DEF_ENEMY_H  = 16;

  localparam int BLINK_MS     = 250;
  localparam int BLINK_INV_MS = 125;
  localparam logic [3:0] WIN_SCORE = 4'd15;

`ifdef GAME_LIVES_EN
  localparam int INVULN_MS = 1000;
  localparam logic [1:0] NUM_LIVES = 2'd3;
`endif

  // Sums are formed at 17 bits so sprites near the 16-bit edge do not wrap.
  function automatic logic overlap(input logic [15:0] a, input logic [15:0] b,
                                   input logic [16:0] a_len, input logic [16:0] b_len);
    return ({1'b0, a} < ({1'b0, b} + b_len)) && ({1'b0, b} < ({1'b0, a} + a_len));
  endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchroniser followed by a registered rising-edge detector;
// emits a single clk-wide pulse three clocks after the input rises.
module edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic pulse_o
);

  logic s0_q, s1_q, prev_q, pulse_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_q    <= 1'b0;
      s1_q    <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      s0_q    <= d_i;
      s1_q    <= s0_q;
      prev_q  <= s1_q;
      pulse_q <= s1_q & ~prev_q;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/game_ctrl.sv
// Game controller: IDLE/PLAY/DEAD/WIN flow, collision, scoring and status LED.
// Optional macro GAME_LIVES_EN adds three lives with post-hit invulnerability.
module game_ctrl
  import game_pkg::*;
#(
  parameter int PLAYER_W = DEF_PLAYER_W,
  parameter int PLAYER_H = DEF_PLAYER_H,
  parameter int ENEMY_W  = DEF_ENEMY_W,
  parameter int ENEMY_H  = DEF_ENEMY_H,
  parameter int SCORE_MS = 1000,
  parameter int DEAD_MS  = 2000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_1ms,
  input  logic        button,
  input  logic        button1,
  input  logic [15:0] x_player,
  input  logic [15:0] y_player,
  input  logic [15:0] x_enemy,
  input  logic [15:0] y_enemy,
  output logic [1:0]  game_state,
  output logic [3:0]  p1_score,
  output logic        player_dead,
  output logic        led
);

  localparam logic [15:0] SCORE_LAST     = 16'(SCORE_MS - 1);
  localparam logic [15:0] DEAD_LAST      = 16'(DEAD_MS - 1);
  localparam logic [7:0]  BLINK_LAST     = 8'(BLINK_MS - 1);
  localparam logic [7:0]  BLINK_INV_LAST = 8'(BLINK_INV_MS - 1);

  game_state_t state_q;
  logic [3:0]  score_q;
  logic [15:0] ms_q, tmr_q;
  logic [7:0]  blink_q;
  logic        dead_q, led_q, hit_q;
  logic        start0_p, start1_p, start_p, tick_p;
  logic        fatal_s, inv_s;

  edge_sync u_sync_btn0 (.clk(clk), .rst_n(reset), .d_i(button),  .pulse_o(start0_p));
  edge_sync u_sync_btn1 (.clk(clk), .rst_n(reset), .d_i(button1), .pulse_o(start1_p));
  edge_sync u_sync_tick (.clk(clk), .rst_n(reset), .d_i(clk_1ms), .pulse_o(tick_p));

  assign start_p = start0_p | start1_p;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_q <= 1'b0;
    end else begin
      hit_q <= overlap(x_player, x_enemy, 17'(PLAYER_W), 17'(ENEMY_W)) &&
               overlap(y_player, y_enemy, 17'(PLAYER_H), 17'(ENEMY_H));
    end
  end

`ifdef GAME_LIVES_EN
  localparam logic [15:0] INV_LOAD = 16'(INVULN_MS);

  logic [1:0]  lives_q;
  logic [15:0] inv_q;
  logic        hit_ok_s;

  assign hit_ok_s = hit_q && (inv_q == 16'd0);
  assign fatal_s  = hit_ok_s && (lives_q == 2'd1);
  assign inv_s    = (inv_q != 16'd0);

  // A non-fatal hit costs a life and opens an invulnerability window.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lives_q <= 2'd0;
      inv_q   <= 16'd0;
    end else if (state_q == ST_IDLE && start_p) begin
      lives_q <= NUM_LIVES;
      inv_q   <= 16'd0;
    end else if (state_q == ST_PLAY) begin
      if (hit_ok_s && !fatal_s) begin
        lives_q <= lives_q - 2'd1;
        inv_q   <= INV_LOAD;
      end else if (tick_p && inv_s) begin
        inv_q <= inv_q - 16'd1;
      end
    end
  end
`else
  assign fatal_s = hit_q;
  assign inv_s   = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      score_q <= 4'd0;
      ms_q    <= 16'd0;
      tmr_q   <= 16'd0;
      blink_q <= 8'd0;
      dead_q  <= 1'b0;
      led_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          led_q <= 1'b0;
          if (start_p) begin
            state_q <= ST_PLAY;
            score_q <= 4'd0;
            ms_q    <= 16'd0;
            blink_q <= 8'd0;
            led_q   <= 1'b1;
          end
        end
        ST_PLAY: begin
          if (fatal_s) begin
            state_q <= ST_DEAD;
            dead_q  <= 1'b1;
            tmr_q   <= 16'd0;
            blink_q <= 8'd0;
            led_q   <= 1'b1;
          end else begin
            if (!inv_s) begin
              led_q   <= 1'b1;
              blink_q <= 8'd0;
            end else if (tick_p) begin
              if (blink_q == BLINK_INV_LAST) begin
                blink_q <= 8'd0;
                led_q   <= ~led_q;
              end else begin
                blink_q <= blink_q + 8'd1;
              end
            end
            // Later assignments here override the LED blink on the winning point.
            if (tick_p) begin
              if (ms_q == SCORE_LAST) begin
                ms_q    <= 16'd0;
                score_q <= score_q + 4'd1;
                if (score_q == WIN_SCORE - 4'd1) begin
                  state_q <= ST_WIN;
                  tmr_q   <= 16'd0;
                  blink_q <= 8'd0;
                  led_q   <= 1'b1;
                end
              end else begin
                ms_q <= ms_q + 16'd1;
              end
            end
          end
        end
        ST_DEAD, ST_WIN: begin
          if (start_p || (tick_p && tmr_q == DEAD_LAST)) begin
            state_q <= ST_IDLE;
            dead_q  <= 1'b0;
            led_q   <= 1'b0;
          end else if (tick_p) begin
            tmr_q <= tmr_q + 16'd1;
            if (blink_q == BLINK_LAST) begin
              blink_q <= 8'd0;
              led_q   <= ~led_q;
            end else begin
              blink_q <= blink_q + 8'd1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign game_state  = state_q;
  assign p1_score    = score_q;
  assign player_dead = dead_q;
  assign led         = led_q;

endmodule
